// File: rtl/parking_sensor_gen.sv
// Parking-gate sensor emulator: plays entry/exit sensor waveforms on request
// and tracks a saturating model of how many cars are parked.
module parking_sensor_gen #(
  parameter int HOLD = 4,
  parameter int GAP  = 2,
  parameter int CAP  = 10
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       req_entry,
  input  logic       req_exit,
  output logic [1:0] sens_entry,
  output logic       sens_exit,
  output logic       busy,
  output logic       done,
  output logic       reject,
  output logic       drop,
  output logic [3:0] cars,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_E_APPR  = 3'd1,
    S_E_UNDER = 3'd2,
    S_E_LEAVE = 3'd3,
    S_X_UNDER = 3'd4,
    S_GAP     = 3'd5
  } state_e;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = 8'(GAP - 1);
  localparam logic [3:0] CAP_V   = 4'(CAP);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] cars_q, cars_d;
  logic [1:0] sens_entry_q, sens_entry_d;
  logic       sens_exit_q, sens_exit_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       reject_q, reject_d;
  logic       drop_q, drop_d;

  // Next-state logic; every output is derived from the next state so that
  // the registered outputs line up with the state they describe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cars_d   = cars_q;
    done_d   = 1'b0;
    reject_d = 1'b0;
    drop_d   = (state_q != S_IDLE) && (req_entry || req_exit);
    case (state_q)
      S_IDLE: begin
        if (req_exit && (cars_q != 4'd0)) begin
          state_d = S_X_UNDER;
          cnt_d   = HOLD_M1;
        end else if (req_entry && (cars_q < CAP_V)) begin
          state_d = S_E_APPR;
          cnt_d   = HOLD_M1;
        end else if (req_entry || req_exit) begin
          reject_d = 1'b1;
        end
      end
      S_E_APPR: begin
        if (cnt_q == 8'd0) begin
          state_d = S_E_UNDER;
          cnt_d   = HOLD_M1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_E_UNDER: begin
        if (cnt_q == 8'd0) begin
          state_d = S_E_LEAVE;
          cnt_d   = HOLD_M1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_E_LEAVE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_GAP;
          cnt_d   = GAP_M1;
          done_d  = 1'b1;
          cars_d  = cars_q + 4'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_X_UNDER: begin
        if (cnt_q == 8'd0) begin
          state_d = S_GAP;
          cnt_d   = GAP_M1;
          done_d  = 1'b1;
          cars_d  = cars_q - 4'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    busy_d      = (state_d != S_IDLE);
    sens_exit_d = (state_d == S_X_UNDER);
    case (state_d)
      S_E_APPR:  sens_entry_d = 2'b01;
      S_E_UNDER: sens_entry_d = 2'b11;
      S_E_LEAVE: sens_entry_d = 2'b10;
      default:   sens_entry_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      cars_q       <= 4'd0;
      sens_entry_q <= 2'b00;
      sens_exit_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      reject_q     <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cars_q       <= cars_d;
      sens_entry_q <= sens_entry_d;
      sens_exit_q  <= sens_exit_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      reject_q     <= reject_d;
      drop_q       <= drop_d;
    end
  end

  assign sens_entry = sens_entry_q;
  assign sens_exit  = sens_exit_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign reject     = reject_q;
  assign drop       = drop_q;
  assign cars       = cars_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Directed bench for parking_sensor_gen with HOLD=4, GAP=2, CAP=10.
module tb_parking_sensor_gen;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic       req_entry = 1'b0;
  logic       req_exit = 1'b0;
  logic [1:0] sens_entry;
  logic       sens_exit;
  logic       busy;
  logic       done;
  logic       reject;
  logic       drop;
  logic [3:0] cars;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;

  parking_sensor_gen #(.HOLD(4), .GAP(2), .CAP(10)) dut (
    .clk_2(clk_2), .reset(reset), .req_entry(req_entry), .req_exit(req_exit),
    .sens_entry(sens_entry), .sens_exit(sens_exit), .busy(busy), .done(done),
    .reject(reject), .drop(drop), .cars(cars), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_entry = 1'b0;
    req_exit = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle: busy=%b required 0 after %0d cycles", busy, n);
    end
  endtask

  task automatic do_entry();
    req_entry = 1'b1;
    tick();
    req_entry = 1'b0;
    wait_idle(40);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if ({sens_entry, sens_exit, busy, done, reject, drop, cars, state_dbg} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: se=%b sx=%b busy=%b done=%b rej=%b drop=%b cars=%0d st=%0d required all 0",
               sens_entry, sens_exit, busy, done, reject, drop, cars, state_dbg);
    end
    do_reset();
  endtask

  task automatic test_exit_empty();
    req_exit = 1'b1;
    tick();
    req_exit = 1'b0;
    checks++;
    if (reject !== 1'b1 || busy !== 1'b0 || sens_exit !== 1'b0 || cars !== 4'd0) begin
      failures++;
      $display("FAIL exit_empty: reject=%b busy=%b sens_exit=%b cars=%0d required 1 0 0 0",
               reject, busy, sens_exit, cars);
    end
    tick();
    checks++;
    if (reject !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL exit_empty_pulse: reject=%b busy=%b required 0 0", reject, busy);
    end
  endtask

  task automatic test_entry();
    logic [1:0] exp_se;
    req_entry = 1'b1;
    tick();
    req_entry = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_se = (i < 4) ? 2'b01 : (i < 8) ? 2'b11 : 2'b10;
      checks++;
      if (sens_entry !== exp_se || done !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL entry_phase[%0d]: se=%b done=%b busy=%b required %b 0 1",
                 i, sens_entry, done, busy, exp_se);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || cars !== 4'd1 || sens_entry !== 2'b00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL entry_done: done=%b cars=%0d se=%b busy=%b required 1 1 00 1",
               done, cars, sens_entry, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL entry_gap1: done=%b busy=%b required 0 1", done, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || cars !== 4'd1) begin
      failures++;
      $display("FAIL entry_idle: busy=%b cars=%0d required 0 1", busy, cars);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      do_entry();
      checks++;
      if (cars !== 4'(k + 1)) begin
        failures++;
        $display("FAIL fill_cars[%0d]: cars=%0d required %0d", k, cars, k + 1);
      end
    end
    req_entry = 1'b1;
    tick();
    req_entry = 1'b0;
    checks++;
    if (reject !== 1'b1 || cars !== 4'd10 || busy !== 1'b0 || sens_entry !== 2'b00) begin
      failures++;
      $display("FAIL fill_full: reject=%b cars=%0d busy=%b se=%b required 1 10 0 00",
               reject, cars, busy, sens_entry);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < 3; k++) do_entry();
    req_entry = 1'b1;
    req_exit = 1'b1;
    tick();
    req_entry = 1'b0;
    req_exit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sens_exit !== 1'b1 || sens_entry !== 2'b00 || done !== 1'b0) begin
        failures++;
        $display("FAIL simul_exit[%0d]: sx=%b se=%b done=%b required 1 00 0",
                 i, sens_exit, sens_entry, done);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || cars !== 4'd2 || sens_exit !== 1'b0) begin
      failures++;
      $display("FAIL simul_done: done=%b cars=%0d sx=%b required 1 2 0", done, cars, sens_exit);
    end
    wait_idle(10);
  endtask

  task automatic test_drop();
    int n;
    req_entry = 1'b1;
    tick();
    req_entry = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    req_entry = 1'b1;
    tick();
    req_entry = 1'b0;
    checks++;
    if (drop !== 1'b1 || sens_entry !== 2'b11) begin
      failures++;
      $display("FAIL drop_pulse: drop=%b se=%b required 1 11", drop, sens_entry);
    end
    tick();
    checks++;
    if (drop !== 1'b0) begin
      failures++;
      $display("FAIL drop_once: drop=%b required 0", drop);
    end
    n = 6;
    while (done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 12 || cars !== 4'd3) begin
      failures++;
      $display("FAIL drop_done: done at cycle %0d cars=%0d required 12 3", n, cars);
    end
    wait_idle(10);
    checks++;
    if (cars !== 4'd3 || state_dbg !== 3'd0) begin
      failures++;
      $display("FAIL drop_final: cars=%0d state=%0d required 3 0", cars, state_dbg);
    end
  endtask

  task automatic test_async_reset();
    req_entry = 1'b1;
    tick();
    req_entry = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({sens_entry, sens_exit, busy, done, reject, drop, cars} !== 10'd0) begin
      failures++;
      $display("FAIL async_reset: se=%b sx=%b busy=%b done=%b cars=%0d required all 0",
               sens_entry, sens_exit, busy, done, cars);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 2) reset = 1'b1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || cars !== 4'd0) begin
        failures++;
        $display("FAIL async_after[%0d]: done=%b busy=%b cars=%0d required 0 0 0",
                 i, done, busy, cars);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exit_empty();
    test_entry();
    test_fill();
    test_simultaneous();
    test_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parking_sensor_gen.md
PARKING_SENSOR_GEN -- requirements
Module: parking_sensor_gen

Interface
REQ-001 Parameter HOLD, default 4, cycles each sensor phase is held (legal range 1..255).
REQ-002 Parameter GAP, default 2, idle cycles forced after every completed sequence (legal range 1..255).
REQ-003 Parameter CAP, default 10, lot capacity tracked by the internal car model (legal range 1..15).
REQ-004 clk_2  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted at 0, released at 1.
REQ-006 req_entry  input  1  request to emulate one car entering; sampled only in IDLE.
REQ-007 req_exit  input  1  request to emulate one car leaving; sampled only in IDLE.
REQ-008 sens_entry  output  2  emulated entry-gate sensor pair, bit1 = car under barrier, bit0 = car approaching.
REQ-009 sens_exit  output  1  emulated exit-gate sensor, 1 = car under barrier.
REQ-010 busy  output  1  high while a sequence or the post-sequence gap is in progress.
REQ-011 done  output  1  one-cycle pulse when a sequence completes.
REQ-012 reject  output  1  one-cycle pulse when an IDLE request is refused by the capacity model.
REQ-013 drop  output  1  one-cycle pulse when any request arrives while busy is high.
REQ-014 cars  output  4  internal model of the number of parked cars.

Function
REQ-015 States: IDLE, E_APPR, E_UNDER, E_LEAVE, X_UNDER, GAP; a single phase counter times all states except IDLE.
REQ-016 sens_entry: 2'b01 in E_APPR, 2'b11 in E_UNDER, 2'b10 in E_LEAVE, 2'b00 elsewhere.
REQ-017 sens_exit: 1 in X_UNDER, 0 elsewhere.
REQ-018 All outputs are registered; no output depends combinationally on req_entry or req_exit.
REQ-019 IDLE, req_exit=1, cars>0: next state X_UNDER.
REQ-020 IDLE, req_entry=1, req_exit not accepted, cars<CAP: next state E_APPR.
REQ-021 Simultaneous req_entry and req_exit in IDLE: exit has priority when cars>0; otherwise entry is evaluated.
REQ-022 IDLE, request present but refused (entry with cars==CAP, exit with cars==0, and no other request accepted): reject=1 for one cycle; state stays IDLE.
REQ-023 Each of E_APPR, E_UNDER, E_LEAVE and X_UNDER lasts exactly HOLD cycles.
REQ-024 Order: E_APPR -> E_UNDER -> E_LEAVE -> GAP; X_UNDER -> GAP.
REQ-025 On entering GAP: done=1 for one cycle; cars+1 after an entry sequence, cars-1 after an exit sequence.
REQ-026 GAP lasts exactly GAP cycles, then the state returns to IDLE.
REQ-027 busy=1 in every state except IDLE.
REQ-028 Latency: an accepted entry request produces done 3*HOLD cycles after the accepting edge; an accepted exit request produces done HOLD cycles after the accepting edge.
REQ-029 Any request while busy=1: drop=1 in the following cycle; the request is discarded, not queued.
REQ-030 cars saturates: never exceeds CAP and never goes below 0 (guaranteed by REQ-019/020).
REQ-031 Sequences are never aborted except by reset.

Reset
REQ-032 reset=0 forces, asynchronously: state IDLE, phase counter 0, cars=0, sens_entry=2'b00, sens_exit=0, busy=0, done=0, reject=0, drop=0.
REQ-033 Reset asserted mid-sequence abandons the sequence with no done pulse and no change to cars beyond the clear.
REQ-034 First request is sampled on the first rising clk_2 edge after reset returns to 1.

Verification
REQ-035 HOLD=4, GAP=2, reset, one-cycle req_entry pulse -> sens_entry 01, 11, 10 for 4 cycles each; done at cycle 12; cars=1; busy low 2 cycles later.
REQ-036 cars=0, req_exit pulse -> reject pulse, sens_exit stays 0, cars=0, busy stays 0.
REQ-037 11 back-to-back entry requests (each issued when busy=0) -> cars reaches 10; 11th request gives reject and cars stays 10.
REQ-038 cars=3, req_entry and req_exit asserted in the same cycle -> exit sequence only (sens_exit high 4 cycles); cars=2.
REQ-039 req_entry pulse during E_UNDER -> drop pulse next cycle; the sequence completes unchanged; cars increments by 1 only.
REQ-040 reset driven to 0 asynchronously during E_UNDER -> all outputs clear immediately without a clock edge; no done pulse; cars=0.
